// File: rtl/audio_clkgen_nco.sv
// Multi-channel NCO audio clock generator: one phase accumulator per channel, glitch-free run-time retune.
// Define CLKGEN_PHASE_ALIGN_EN to apply a retune immediately and restart every channel at phase 0.
module audio_clkgen_nco #(
    parameter int unsigned             NUM_CH      = 3,
    parameter int unsigned             ACC_W       = 32,
    parameter int unsigned             LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = {32'd1055531163, 32'd4123169, 32'd131941395}
) (
    input  logic                                         i_refclk,
    input  logic                                         i_rst,
    input  logic                                         i_en,
    input  logic                                         i_cfg_valid,
    output logic                                         o_cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_cfg_ch,
    input  logic [ACC_W-1:0]                             i_cfg_inc,
    output logic [NUM_CH-1:0]                            o_outclk,
    output logic [NUM_CH-1:0]                            o_outstb,
    output logic                                         o_locked
);

    localparam int unsigned      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned      CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

    logic [ACC_W-1:0]  r_acc [NUM_CH];
    logic [ACC_W-1:0]  r_inc [NUM_CH];
    logic [NUM_CH-1:0] r_stb;
    logic              r_pend_v;
    logic [CH_W-1:0]   r_pend_ch;
    logic [ACC_W-1:0]  r_pend_inc;
    logic              r_ready;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_locked;

    logic [ACC_W:0]    w_sum [NUM_CH];
    logic [NUM_CH-1:0] w_hit;
    logic              w_xfer;
    logic              w_ch_ok;
    logic              w_apply;
    logic [ACC_W-1:0]  w_acc_nxt [NUM_CH];
    logic [ACC_W-1:0]  w_inc_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_stb_nxt;
    logic              w_pend_v_nxt;
    logic [CH_W-1:0]   w_pend_ch_nxt;
    logic [ACC_W-1:0]  w_pend_inc_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Next-state: accumulate, decide when the pending increment lands, track lock
    always_comb begin
        w_xfer  = i_cfg_valid && r_ready;
        w_ch_ok = 32'(i_cfg_ch) < NUM_CH;
        w_apply = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
            w_hit[i] = r_pend_v && (r_pend_ch == CH_W'(i));
`ifndef CLKGEN_PHASE_ALIGN_EN
            // Swap on the carry so the current period completes untouched
            if (w_hit[i] && ((i_en && w_sum[i][ACC_W]) || (r_inc[i] == '0))) begin
                w_apply = 1'b1;
            end
`endif
        end
`ifdef CLKGEN_PHASE_ALIGN_EN
        w_apply = r_pend_v;
`endif

        for (int i = 0; i < NUM_CH; i++) begin
            w_acc_nxt[i] = r_acc[i];
            w_inc_nxt[i] = r_inc[i];
            w_stb_nxt[i] = 1'b0;
            if (i_en) begin
                w_acc_nxt[i] = w_sum[i][ACC_W-1:0];
                w_stb_nxt[i] = w_sum[i][ACC_W-1] & ~r_acc[i][ACC_W-1];
            end
            if (w_apply && w_hit[i]) begin
                w_inc_nxt[i] = r_pend_inc;
            end
`ifdef CLKGEN_PHASE_ALIGN_EN
            if (w_apply) begin
                w_acc_nxt[i] = '0;
                w_stb_nxt[i] = 1'b0;
            end
`endif
        end

        w_pend_v_nxt   = r_pend_v;
        w_pend_ch_nxt  = r_pend_ch;
        w_pend_inc_nxt = r_pend_inc;
        if (w_apply) begin
            w_pend_v_nxt = 1'b0;
        end
        // Out-of-range channels are accepted and dropped
        if (w_xfer && w_ch_ok) begin
            w_pend_v_nxt   = 1'b1;
            w_pend_ch_nxt  = i_cfg_ch;
            w_pend_inc_nxt = i_cfg_inc;
        end

        w_cnt_nxt = r_cnt;
        if (w_apply || !i_en) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != LOCK_MAX) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_inc[i] <= INC_INIT[i*ACC_W +: ACC_W];
            end
            r_stb      <= '0;
            r_pend_v   <= 1'b0;
            r_pend_ch  <= '0;
            r_pend_inc <= '0;
            r_ready    <= 1'b0;
            r_cnt      <= '0;
            r_locked   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= w_acc_nxt[i];
                r_inc[i] <= w_inc_nxt[i];
            end
            r_stb      <= w_stb_nxt;
            r_pend_v   <= w_pend_v_nxt;
            r_pend_ch  <= w_pend_ch_nxt;
            r_pend_inc <= w_pend_inc_nxt;
            r_ready    <= ~w_pend_v_nxt;
            r_cnt      <= w_cnt_nxt;
            r_locked   <= (w_cnt_nxt == LOCK_MAX);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            o_outclk[i] = r_acc[i][ACC_W-1];
        end
    end

    assign o_outstb    = r_stb;
    assign o_cfg_ready = r_ready;
    assign o_locked    = r_locked;

endmodule
